// File: rtl/adder_nios2_processor_cpu_mult_combine_pkg.sv
// Shared CPU multiplier types and helpers.
// Holds the multiplier half-word width, the partial-product record coming out
// of the multiplier cell, the pipeline-slot record used by the combine stages,
// and the helper that forms the 16-bit middle sum.
package adder_nios2_processor_cpu_mult_combine_pkg;

    localparam int MUL_HALF_W = 16;
    localparam int MUL_W      = 2 * MUL_HALF_W;

    // Registered partial products from the multiplier cell.
    typedef struct packed {
        logic [MUL_W-1:0] p1;   // lo(src1)*lo(src2)
        logic [MUL_W-1:0] p2;   // lo(src1)*hi(src2)
        logic [MUL_W-1:0] p3;   // hi(src1)*lo(src2)
    } mul_partials_t;

    // One pipeline slot: the low product and the folded middle half-word.
    typedef struct packed {
        logic                  valid;
        logic [MUL_W-1:0]      p1;
        logic [MUL_HALF_W-1:0] mid;
    } mul_slot_t;

    // Only the low half of the cross products can reach the low result word,
    // and only after a 16-bit shift, so the carry out of this sum is dropped.
    function automatic logic [MUL_HALF_W-1:0] mid_sum(
        input logic [MUL_W-1:0] p2,
        input logic [MUL_W-1:0] p3
    );
        return p2[MUL_HALF_W-1:0] + p3[MUL_HALF_W-1:0];
    endfunction

endpackage

// File: rtl/adder_nios2_processor_cpu_mult_combine_add.sv
// Final combine adder: sum = p1 + (mid << 16), modulo 2^32.
// Ports:
//   p1  - low partial product lo(src1)*lo(src2)
//   mid - folded middle half-word
//   sum - low 32 bits of the product
module adder_nios2_processor_cpu_mult_combine_add
    import adder_nios2_processor_cpu_mult_combine_pkg::*;
(
    input  logic [MUL_W-1:0]      p1,
    input  logic [MUL_HALF_W-1:0] mid,
    output logic [MUL_W-1:0]      sum
);

    assign sum = p1 + {mid, {MUL_HALF_W{1'b0}}};

endmodule

// File: rtl/adder_nios2_processor_cpu_mult_combine.sv
// Combines the three registered 16x16 partial products of the CPU multiplier
// cell into the 32-bit MUL result (low word of the product; identical for
// signed and unsigned operands).
// Stage A folds the cross products into a 16-bit middle term; stage B (when
// RESULT_STAGES=2) registers the final sum. Both stages advance in lock-step
// on M_en; M_en low holds everything, including valids.
// Ports:
//   clk, reset_n    - clock and asynchronous active-low reset
//   M_en            - pipeline advance enable
//   M_mul           - M-stage instruction is a MUL with valid partials
//   M_flush         - kill the slot entering stage A this cycle
//   M_mul_cell_p1/2/3 - partial products from the multiplier cell
//   W_mul_valid     - W_mul_result holds a live MUL result
//   W_mul_result    - low 32 bits of the product
//   mul_busy        - a live MUL is in stage A or B
module adder_nios2_processor_cpu_mult_combine
    import adder_nios2_processor_cpu_mult_combine_pkg::*;
#(
    parameter int RESULT_STAGES = 2,
    parameter int DATA_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              M_en,
    input  logic              M_mul,
    input  logic              M_flush,
    input  logic [DATA_W-1:0] M_mul_cell_p1,
    input  logic [DATA_W-1:0] M_mul_cell_p2,
    input  logic [DATA_W-1:0] M_mul_cell_p3,
    output logic              W_mul_valid,
    output logic [DATA_W-1:0] W_mul_result,
    output logic              mul_busy
);

    if (DATA_W != 32) begin : g_bad_width
        $error("adder_nios2_processor_cpu_mult_combine: DATA_W must be 32");
    end

    if (RESULT_STAGES != 1 && RESULT_STAGES != 2) begin : g_bad_stages
        $error("adder_nios2_processor_cpu_mult_combine: RESULT_STAGES must be 1 or 2");
    end

    mul_partials_t    partials_s;
    mul_slot_t        a_slot_r;
    logic [MUL_W-1:0] a_sum_s;
    logic             unused_s;

    assign partials_s.p1 = M_mul_cell_p1;
    assign partials_s.p2 = M_mul_cell_p2;
    assign partials_s.p3 = M_mul_cell_p3;

    // Upper halves of the cross products land at bit 32 and above.
    assign unused_s = ^{partials_s.p2[MUL_W-1:MUL_HALF_W],
                        partials_s.p3[MUL_W-1:MUL_HALF_W]};

    // Stage A: capture p1 and the middle sum on every advance; data is not
    // gated by valid, only the valid bit reflects MUL/flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_slot_r <= '0;
        end else if (M_en) begin
            a_slot_r.valid <= M_mul & ~M_flush;
            a_slot_r.p1    <= partials_s.p1;
            a_slot_r.mid   <= mid_sum(partials_s.p2, partials_s.p3);
        end
    end

    adder_nios2_processor_cpu_mult_combine_add u_add (
        .p1  (a_slot_r.p1),
        .mid (a_slot_r.mid),
        .sum (a_sum_s)
    );

    if (RESULT_STAGES == 2) begin : g_stage_b
        logic             b_valid_r;
        logic [MUL_W-1:0] b_result_r;

        // Stage B: register the final sum alongside the slot valid.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                b_valid_r  <= 1'b0;
                b_result_r <= '0;
            end else if (M_en) begin
                b_valid_r  <= a_slot_r.valid;
                b_result_r <= a_sum_s;
            end
        end

        assign W_mul_valid  = b_valid_r;
        assign W_mul_result = b_result_r;
        assign mul_busy     = a_slot_r.valid | b_valid_r;
    end else begin : g_comb_result
        assign W_mul_valid  = a_slot_r.valid;
        assign W_mul_result = a_sum_s;
        assign mul_busy     = a_slot_r.valid;
    end

endmodule
